my_fifo: RTL and testbench

- Synchronous single-clock FIFO buffer with a shift-register storage array and a tail index, i.e. an occupancy count.
- Used as a generic data queue between a producer and a consumer in the same clock domain.
- Read data is registered; full and empty status flags and the count are exported for flow control.

---
 rtl/my_fifo_pkg.sv | 17 +
 rtl/my_fifo.sv | 101 ++++++++++
 tb/tb_my_fifo.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/my_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : my_fifo_pkg
// Brief    : Shared default sizes for the my_fifo shift-register FIFO.
// Revision : 1.0 - initial release
// ============================================================================
package my_fifo_pkg;

  // Default data word width in bits
  localparam int c_bit_depth = 8;
  // Default number of storage entries (at least 2)
  localparam int c_fifo_volume = 8;
  // Default width of the occupancy count, which spans 0..c_fifo_volume
  localparam int c_fifo_volume_bit_depth = $clog2(c_fifo_volume + 1);

endpackage : my_fifo_pkg
`default_nettype wire

// File: rtl/my_fifo.sv
`default_nettype none
// ============================================================================
// Module   : my_fifo
// Brief    : Single-clock FIFO built as a shift register. Entry 0 is always
//            the oldest word; the tail index doubles as the occupancy count.
//            A pop shifts every entry down one place, and read data is
//            registered.
// Revision : 1.0 - initial release
// ============================================================================
module my_fifo
  import my_fifo_pkg::*;
#(
  parameter int BIT_DEPTH             = c_bit_depth,
  parameter int FIFO_VOLUME           = c_fifo_volume,
  parameter int FIFO_VOLUME_BIT_DEPTH = $clog2(FIFO_VOLUME + 1)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             enable_read,
  input  logic                             enable_write,
  input  logic [BIT_DEPTH-1:0]             value_to_write,
  output logic [BIT_DEPTH-1:0]             value_to_read,
  output logic                             full,
  output logic                             empty,
  output logic [FIFO_VOLUME_BIT_DEPTH-1:0] count
);

  localparam logic [FIFO_VOLUME_BIT_DEPTH-1:0] c_full_count = FIFO_VOLUME_BIT_DEPTH'(FIFO_VOLUME);
  localparam logic [FIFO_VOLUME_BIT_DEPTH-1:0] c_one        = FIFO_VOLUME_BIT_DEPTH'(1);

  logic [BIT_DEPTH-1:0]             FIFO_array [FIFO_VOLUME];
  logic [FIFO_VOLUME_BIT_DEPTH-1:0] FIFO_tail_index;

  logic                             w_rd_ok;
  logic                             w_wr_ok;
  logic [FIFO_VOLUME_BIT_DEPTH-1:0] w_wr_idx;
  logic [FIFO_VOLUME_BIT_DEPTH-1:0] w_tail_next;
  logic [BIT_DEPTH-1:0]             w_array_next [FIFO_VOLUME];

  // A pop needs data; a push on a full FIFO is only legal when a pop frees a slot in the same cycle
  always_comb begin
    w_rd_ok = enable_read && (FIFO_tail_index != '0);
    w_wr_ok = enable_write && ((FIFO_tail_index != c_full_count) || w_rd_ok);
    // After a pop the whole array moves down, so the free slot is one lower
    w_wr_idx = w_rd_ok ? (FIFO_tail_index - c_one) : FIFO_tail_index;
  end

  // Next array contents: optional shift-down followed by the optional insert at the tail
  always_comb begin
    w_array_next = FIFO_array;
    if (w_rd_ok) begin
      for (int i = 0; i < FIFO_VOLUME - 1; i++) begin
        w_array_next[i] = FIFO_array[i+1];
      end
    end
    if (w_wr_ok) begin
      // Compare against each slot rather than index directly, keeping the index width decoupled from the array size
      for (int i = 0; i < FIFO_VOLUME; i++) begin
        if (w_wr_idx == FIFO_VOLUME_BIT_DEPTH'(i)) begin
          w_array_next[i] = value_to_write;
        end
      end
    end
  end

  // Next tail index: simultaneous pop and push leaves occupancy unchanged
  always_comb begin
    w_tail_next = FIFO_tail_index;
    if (w_rd_ok && !w_wr_ok) begin
      w_tail_next = FIFO_tail_index - c_one;
    end else if (w_wr_ok && !w_rd_ok) begin
      w_tail_next = FIFO_tail_index + c_one;
    end
  end

  // State registers; reset clears storage so unused entries never read as X
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_VOLUME; i++) begin
        FIFO_array[i] <= '0;
      end
      FIFO_tail_index <= '0;
      value_to_read   <= '0;
    end else begin
      FIFO_array      <= w_array_next;
      FIFO_tail_index <= w_tail_next;
      if (w_rd_ok) begin
        value_to_read <= FIFO_array[0];
      end
    end
  end

  // Status flags derived directly from occupancy
  always_comb begin
    count = FIFO_tail_index;
    full  = (FIFO_tail_index == c_full_count);
    empty = (FIFO_tail_index == '0);
  end

endmodule : my_fifo
`default_nettype wire

// File: tb/tb_my_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_my_fifo
// Brief    : Self-checking bench for my_fifo against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_my_fifo;
  import my_fifo_pkg::*;

  localparam int BD = c_bit_depth;
  localparam int FV = c_fifo_volume;
  localparam int CW = c_fifo_volume_bit_depth;

  logic          clk;
  logic          rst;
  logic          enable_read;
  logic          enable_write;
  logic [BD-1:0] value_to_write;
  logic [BD-1:0] value_to_read;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;

  my_fifo #(
    .BIT_DEPTH            (BD),
    .FIFO_VOLUME          (FV),
    .FIFO_VOLUME_BIT_DEPTH(CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable_read   (enable_read),
    .enable_write  (enable_write),
    .value_to_write(value_to_write),
    .value_to_read (value_to_read),
    .full          (full),
    .empty         (empty),
    .count         (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a queue holding the stored words, oldest first
  logic [BD-1:0] m_q[$];
  logic [BD-1:0] m_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("value_to_read", 32'(value_to_read), 32'(m_rd));
    chk("count", 32'(count), 32'(m_q.size()));
    chk("full", 32'(full), 32'(m_q.size() == FV));
    chk("empty", 32'(empty), 32'(m_q.size() == 0));
    for (int i = 0; i < m_q.size(); i++) begin
      chk($sformatf("FIFO_array[%0d]", i), 32'(dut.FIFO_array[i]), 32'(m_q[i]));
    end
  endtask

  task automatic check_reset_state();
    chk("rst value_to_read", 32'(value_to_read), 32'd0);
    chk("rst count", 32'(count), 32'd0);
    chk("rst empty", 32'(empty), 32'd1);
    chk("rst full", 32'(full), 32'd0);
    for (int i = 0; i < FV; i++) begin
      chk($sformatf("rst FIFO_array[%0d]", i), 32'(dut.FIFO_array[i]), 32'd0);
    end
  endtask

  // One clock of stimulus; model applies the acceptance rules after the edge
  task automatic step(input logic rd, input logic wr, input logic [BD-1:0] d);
    bit rd_ok;
    bit wr_ok;
    @(negedge clk);
    enable_read    = rd;
    enable_write   = wr;
    value_to_write = d;
    @(posedge clk);
    rd_ok = rd && (m_q.size() != 0);
    wr_ok = wr && ((m_q.size() != FV) || rd_ok);
    if (rd_ok) m_rd = m_q.pop_front();
    if (wr_ok) m_q.push_back(d);
    #1;
    compare_all();
  endtask

  // Reset asserted between edges so its asynchronous effect is visible at once
  task automatic async_reset();
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    m_q.delete();
    m_rd = '0;
    check_reset_state();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int p_rd;
    int p_wr;
    rst            = 1'b1;
    enable_read    = 1'b0;
    enable_write   = 1'b0;
    value_to_write = '0;
    m_rd           = '0;

    async_reset();
    step(1'b0, 1'b0, 8'd0);

    // Read on empty is ignored
    step(1'b1, 1'b0, 8'd0);
    // Read+write on empty: write only, no bypass
    step(1'b1, 1'b1, 8'd7);
    chk("rw7 value_to_read", 32'(value_to_read), 32'd0);
    step(1'b1, 1'b1, 8'd8);
    chk("rw8 value_to_read", 32'(value_to_read), 32'd7);
    // Fill past full; last two writes dropped
    for (int v = 9; v <= 17; v++) step(1'b0, 1'b1, 8'(v));
    chk("fill full", 32'(full), 32'd1);
    chk("fill tail", 32'(dut.FIFO_array[FV-1]), 32'd15);
    // Read+write on full is accepted
    step(1'b1, 1'b1, 8'd18);
    chk("full rw value_to_read", 32'(value_to_read), 32'd8);
    chk("full rw tail", 32'(dut.FIFO_array[FV-1]), 32'd18);
    step(1'b1, 1'b1, 8'd19);
    chk("full rw2 value_to_read", 32'(value_to_read), 32'd9);
    // Drain one beyond empty
    for (int k = 0; k < FV + 1; k++) step(1'b1, 1'b0, 8'd0);
    chk("drain hold", 32'(value_to_read), 32'd19);
    chk("drain empty", 32'(empty), 32'd1);

    // Randomized traffic with phases biased toward filling, draining and mixing
    for (int it = 0; it < 600; it++) begin
      case ((it / 50) % 3)
        0:       begin p_rd = 25; p_wr = 80; end
        1:       begin p_rd = 80; p_wr = 25; end
        default: begin p_rd = 60; p_wr = 60; end
      endcase
      if (it == 330) async_reset();
      step(($urandom_range(0, 99) < p_rd), ($urandom_range(0, 99) < p_wr), BD'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Safety bound so the run always terminates
  initial begin
    #200000;
    $display("FAIL timeout: got 0 expected 1 (run did not complete)");
    $fatal(1, "timeout");
  end

endmodule : tb_my_fifo
`default_nettype wire
